// File: rtl/serial_adder_sub.sv
// serial_adder_sub
//   Multi-cycle add/subtract engine. A DIGIT-bit full-adder slice with a
//   registered carry processes the operands LSB first, DIGIT bits per clock,
//   so an operation takes N = WIDTH/DIGIT RUN cycles.
//
// Parameters
//   WIDTH  operand/result width (multiple of DIGIT)
//   DIGIT  bits per clock, 1..WIDTH
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-high
//   start  in   request, sampled only in IDLE or DONE
//   sub    in   0: a+b+cin, 1: a-b-cin (cin is borrow-in)
//   a, b   in   operands, captured on an accepted start
//   cin    in   carry/borrow in, captured on an accepted start
//   busy   out  high during RUN
//   done   out  one-cycle pulse, s/cout (and ovf) valid
//   s      out  result mod 2^WIDTH
//   cout   out  carry-out (add) / borrow-out (sub)
//   ovf    out  signed overflow, only when SERIAL_ADD_OVF_EN is defined
//
// Optional feature macro: SERIAL_ADD_OVF_EN adds the ovf port and its logic.
//
// Handshake: start is accepted only in IDLE or DONE; while busy=1 it is
// ignored and the captured operands are untouched. done pulses for exactly
// one cycle, and s/cout hold their value from that pulse until the next
// accepted start. A start during the done cycle begins the next op at once.
module serial_adder_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Reject illegal digit sizes at elaboration.
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_adder_sub: DIGIT must divide WIDTH and be in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry;
    logic               sub_r;
    logic [CNT_W-1:0]   cnt;

    logic [DIGIT-1:0]   sum_d;
    logic               c_chain;
    logic               accept;
    logic               last;
    logic [WIDTH+DIGIT-1:0] s_cat;
`ifdef SERIAL_ADD_OVF_EN
    logic               c_msb_in;
`endif

    assign accept = start && (state == ST_IDLE || state == ST_DONE);
    assign last   = (state == ST_RUN) && (cnt == CNT_W'(N - 1));
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    // Ripple across the digit; the chain starts from the registered carry.
    always_comb begin
        sum_d   = '0;
        c_chain = carry;
`ifdef SERIAL_ADD_OVF_EN
        c_msb_in = carry;
`endif
        for (int i = 0; i < DIGIT; i++) begin
`ifdef SERIAL_ADD_OVF_EN
            // Ends up holding the carry into the top bit of the digit,
            // which on the final cycle is the carry into the word MSB.
            c_msb_in = c_chain;
`endif
            sum_d[i] = a_r[i] ^ b_r[i] ^ c_chain;
            c_chain  = (a_r[i] & b_r[i]) | (b_r[i] & c_chain) | (c_chain & a_r[i]);
        end
    end

    // New digit enters at the MSB end; works even when DIGIT == WIDTH.
    assign s_cat = {sum_d, s};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            sub_r <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                // Subtraction is a + ~b + ~cin; borrow is the inverted carry.
                a_r   <= a;
                b_r   <= b ^ {WIDTH{sub}};
                carry <= cin ^ sub;
                sub_r <= sub;
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                s     <= s_cat[WIDTH+DIGIT-1:DIGIT];
                a_r   <= a_r >> DIGIT;
                b_r   <= b_r >> DIGIT;
                carry <= c_chain;
                cnt   <= cnt + CNT_W'(1);
                if (last) begin
                    cout <= c_chain ^ sub_r;
`ifdef SERIAL_ADD_OVF_EN
                    ovf  <= c_msb_in ^ c_chain;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_sub.sv
module tb_serial_adder_sub;

    logic       clk;
    logic       rst;
    logic       start_v [4];
    logic       sub_v   [4];
    logic [7:0] a_v     [4];
    logic [7:0] b_v     [4];
    logic       cin_v   [4];
    logic       busy_v  [4];
    logic       done_v  [4];
    logic [7:0] s_v     [4];
    logic       cout_v  [4];
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf_v   [4];
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];
`ifdef SERIAL_ADD_OVF_EN
    logic       exp_ovf_q[$];
`endif

    // Instance g uses DIGIT = 1 << g: 1, 2, 4, 8 -> N = 8, 4, 2, 1.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_adder_sub #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_v[g]),
            .sub   (sub_v[g]),
            .a     (a_v[g]),
            .b     (b_v[g]),
            .cin   (cin_v[g]),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .s     (s_v[g]),
            .cout  (cout_v[g])
`ifdef SERIAL_ADD_OVF_EN
            ,
            .ovf   (ovf_v[g])
`endif
        );
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model and scoreboard push.
    task automatic push_exp(input logic [7:0] av, input logic [7:0] bv,
                            input logic cv, input logic sv);
        logic [8:0] full;
        int         r;
        if (!sv) begin
            full = {1'b0, av} + {1'b0, bv} + 9'(cv);
            r    = int'($signed(av)) + int'($signed(bv)) + int'(cv);
        end else begin
            full = {1'b0, av} - {1'b0, bv} - 9'(cv);
            r    = int'($signed(av)) - int'($signed(bv)) - int'(cv);
        end
        exp_q.push_back(full);
`ifdef SERIAL_ADD_OVF_EN
        exp_ovf_q.push_back((r > 127) || (r < -128));
`else
        if (r > 1000) $display("unexpected model value %0d", r);
`endif
    endtask

    // Waits for done on instance idx (already past the accept edge),
    // checks latency against n_exp and compares with the scoreboard head.
    task automatic wait_done_check(input int idx, input int n_exp, input string tag);
        int         cyc = 0;
        bit         seen = 0;
        logic [8:0] exp;
        while (!seen && cyc < 40) begin
            if (done_v[idx]) seen = 1;
            else begin
                tick();
                cyc++;
            end
        end
        if (!seen) begin
            check({tag, "_timeout"}, 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
`ifdef SERIAL_ADD_OVF_EN
            if (exp_ovf_q.size() > 0) void'(exp_ovf_q.pop_front());
`endif
            return;
        end
        check({tag, "_lat"}, cyc, n_exp);
        check({tag, "_busy_in_done"}, busy_v[idx], 0);
        exp = exp_q.pop_front();
        check({tag, "_res"}, {cout_v[idx], s_v[idx]}, exp);
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"}, ovf_v[idx], exp_ovf_q.pop_front());
`endif
    endtask

    // One full op. b2b=1 means start is raised in the current (DONE) cycle.
    task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic sv, input bit b2b, input string tag);
        if (!b2b) tick();
        push_exp(av, bv, cv, sv);
        start_v[idx] = 1'b1;
        a_v[idx]     = av;
        b_v[idx]     = bv;
        cin_v[idx]   = cv;
        sub_v[idx]   = sv;
        tick();
        start_v[idx] = 1'b0;
        check({tag, "_busy"}, busy_v[idx], 1);
        wait_done_check(idx, 8 >> idx, tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int dones;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 0; sub_v[i] = 0; a_v[i] = '0; b_v[i] = '0; cin_v[i] = 0;
        end
        tick();
        tick();
        check("rst_busy", busy_v[0], 0);
        check("rst_done", done_v[0], 0);
        check("rst_s",    s_v[0],    0);
        check("rst_cout", cout_v[0], 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf",  ovf_v[2],  0);
`endif
        rst = 1'b0;
        tick();

        // Directed vectors.
        run_op(0, 8'hFF, 8'h01, 0, 0, 0, "d1_ff_plus_01");
        run_op(0, 8'h05, 8'h07, 0, 1, 0, "d1_05_minus_07");
        run_op(0, 8'h07, 8'h05, 1, 1, 0, "d1_07_minus_05_b");
        run_op(2, 8'h7F, 8'h01, 0, 0, 0, "d4_7f_plus_01");
        run_op(2, 8'h80, 8'h01, 0, 1, 0, "d4_80_minus_01");
        run_op(3, 8'hA5, 8'h5A, 1, 0, 0, "d8_a5_plus_5a_c");
        run_op(1, 8'h12, 8'h34, 0, 0, 0, "d2_12_plus_34");

        // Back-to-back: start raised in the DONE cycle.
        run_op(0, 8'h10, 8'h20, 0, 0, 1, "b2b_d1");
        run_op(2, 8'h00, 8'h01, 0, 1, 1, "b2b_d4");
        tick();
        check("done_single", done_v[2], 0);

        // start toggles and operands change while busy.
        tick();
        push_exp(8'h3C, 8'h0F, 0, 0);
        start_v[0] = 1; a_v[0] = 8'h3C; b_v[0] = 8'h0F; cin_v[0] = 0; sub_v[0] = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            start_v[0] = ~start_v[0];
            a_v[0]     = 8'($urandom_range(0, 255));
            b_v[0]     = 8'($urandom_range(0, 255));
            sub_v[0]   = 1'($urandom_range(0, 1));
            tick();
        end
        start_v[0] = 0;
        wait_done_check(0, 3, "toggle");
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done_v[0]) dones++;
        end
        check("toggle_extra_done", dones, 0);
        check("toggle_idle_busy", busy_v[0], 0);

        // Reset during the third RUN cycle.
        start_v[0] = 1; a_v[0] = 8'hFF; b_v[0] = 8'hFF; cin_v[0] = 1; sub_v[0] = 0;
        tick();
        start_v[0] = 0;
        tick();
        tick();
        check("pre_rst_busy", busy_v[0], 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy_v[0], 0);
        check("mid_rst_done", done_v[0], 0);
        check("mid_rst_s",    s_v[0],    0);
        check("mid_rst_cout", cout_v[0], 0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done_v[0]) dones++;
        end
        check("rst_no_done", dones, 0);
        run_op(0, 8'h12, 8'h34, 0, 0, 0, "post_rst");

        // Random ops across all digit sizes.
        for (int k = 0; k < 1000; k++) begin
            run_op(k % 4, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), "rnd");
        end

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
